// File: rtl/axis_traffic_gen.sv
// AXI-Stream traffic generator: LFSR-paced single-flit packets carrying
// {generation timestamp, per-destination sequence number} toward a mesh port.
module axis_traffic_gen #(
   parameter int unsigned TDATA_WIDTH   = 64,
   parameter int unsigned TDEST_WIDTH   = 2,
   parameter int unsigned TID_WIDTH     = 2,
   parameter int unsigned COUNT_WIDTH   = 32,
   parameter int unsigned NUM_ROUTERS   = 4,
   parameter int unsigned TID           = 0,
   parameter int unsigned SEED          = 2,
   parameter int unsigned PENDING_DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [15:0]                load,
   input  logic [COUNT_WIDTH-1:0]     num_packets,
   input  logic                       start,
   input  logic [TDATA_WIDTH/2-1:0]   ticks,
   output logic                       done,
   output logic [COUNT_WIDTH-1:0]     sent_packets [NUM_ROUTERS],
   output logic [COUNT_WIDTH-1:0]     total_sent_packets,
   output logic                       axis_out_tvalid,
   input  logic                       axis_out_tready,
   output logic [TDATA_WIDTH-1:0]     axis_out_tdata,
   output logic                       axis_out_tlast,
   output logic [TID_WIDTH-1:0]       axis_out_tid,
   output logic [TDEST_WIDTH-1:0]     axis_out_tdest
);

   localparam int unsigned TS_W      = TDATA_WIDTH / 2;
   localparam int unsigned PTR_W     = $clog2(PENDING_DEPTH);
   localparam int unsigned OCC_W     = PTR_W + 1;
   localparam logic [15:0] LFSR_MASK = 16'hB400;
   localparam logic [15:0] RATE_SEED = 16'(SEED);
   localparam logic [15:0] DEST_RAW  = RATE_SEED ^ 16'hACE1;
   localparam logic [15:0] DEST_SEED = (DEST_RAW == 16'd0) ? 16'd1 : DEST_RAW;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

   state_t                 state_q, state_d;
   logic                   start_q;
   logic                   done_q, done_d;
   logic [15:0]            rate_q, rate_d;
   logic [15:0]            dlfsr_q, dlfsr_d;
   logic [COUNT_WIDTH-1:0] gen_cnt_q, gen_cnt_d;
   logic [COUNT_WIDTH-1:0] total_q, total_d;
   logic [COUNT_WIDTH-1:0] sent_q [NUM_ROUTERS];
   logic [COUNT_WIDTH-1:0] sent_d [NUM_ROUTERS];
   logic [TS_W-1:0]        ts_mem_q  [PENDING_DEPTH];
   logic [TS_W-1:0]        ts_mem_d  [PENDING_DEPTH];
   logic [TDEST_WIDTH-1:0] dst_mem_q [PENDING_DEPTH];
   logic [TDEST_WIDTH-1:0] dst_mem_d [PENDING_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]       occ_q, occ_d;
   logic                   valid_q, valid_d;

   logic                   fifo_full;
   logic                   pop_c;
   logic                   push_c;
   logic [TDEST_WIDTH-1:0] head_dest;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
   endfunction

   assign fifo_full = (occ_q == OCC_W'(PENDING_DEPTH));
   assign head_dest = dst_mem_q[rd_ptr_q];
   assign pop_c     = valid_q && axis_out_tready;

   // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
   assign push_c = (state_q == ST_RUN) && (rate_q <= load) && (!fifo_full || pop_c)
                   && (gen_cnt_q < num_packets);

   // Next-state, LFSR, FIFO and counter update.
   always_comb begin
      state_d   = state_q;
      rate_d    = rate_q;
      dlfsr_d   = dlfsr_q;
      gen_cnt_d = gen_cnt_q;
      total_d   = total_q;
      sent_d    = sent_q;
      ts_mem_d  = ts_mem_q;
      dst_mem_d = dst_mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      occ_d     = occ_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start_q) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!(gen_cnt_q < num_packets)) state_d = ST_DRAIN;
            rate_d  = lfsr_next(rate_q);
            dlfsr_d = lfsr_next(dlfsr_q);
         end
         ST_DRAIN: begin
            if (!valid_q) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
      endcase

      if (push_c) begin
         ts_mem_d[wr_ptr_q]  = ticks;
         dst_mem_d[wr_ptr_q] = dlfsr_q[TDEST_WIDTH-1:0];
         wr_ptr_d            = wr_ptr_q + PTR_W'(1);
         gen_cnt_d           = gen_cnt_q + COUNT_WIDTH'(1);
      end

      if (pop_c) begin
         rd_ptr_d          = rd_ptr_q + PTR_W'(1);
         sent_d[head_dest] = sent_q[head_dest] + COUNT_WIDTH'(1);
         total_d           = total_q + COUNT_WIDTH'(1);
      end

      if (push_c && !pop_c)      occ_d = occ_q + OCC_W'(1);
      else if (!push_c && pop_c) occ_d = occ_q - OCC_W'(1);

      valid_d = (occ_d != OCC_W'(0));
      done_d  = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         start_q   <= 1'b0;
         done_q    <= 1'b0;
         rate_q    <= RATE_SEED;
         dlfsr_q   <= DEST_SEED;
         gen_cnt_q <= '0;
         total_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         occ_q     <= '0;
         valid_q   <= 1'b0;
         for (int i = 0; i < NUM_ROUTERS; i++) sent_q[i] <= '0;
         for (int i = 0; i < PENDING_DEPTH; i++) begin
            ts_mem_q[i]  <= '0;
            dst_mem_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         start_q   <= start;
         done_q    <= done_d;
         rate_q    <= rate_d;
         dlfsr_q   <= dlfsr_d;
         gen_cnt_q <= gen_cnt_d;
         total_q   <= total_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         occ_q     <= occ_d;
         valid_q   <= valid_d;
         sent_q    <= sent_d;
         ts_mem_q  <= ts_mem_d;
         dst_mem_q <= dst_mem_d;
      end
   end

   // Payload is the FIFO head; its sequence number only moves on a handshake.
   assign done               = done_q;
   assign sent_packets       = sent_q;
   assign total_sent_packets = total_q;
   assign axis_out_tvalid    = valid_q;
   assign axis_out_tdata     = {ts_mem_q[rd_ptr_q], TS_W'(sent_q[head_dest])};
   assign axis_out_tlast     = valid_q;
   assign axis_out_tid       = TID_WIDTH'(TID);
   assign axis_out_tdest     = head_dest;

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Randomized bench for axis_traffic_gen against a queue-based packet model.
module tb_axis_traffic_gen;

   localparam int unsigned DW     = 64;
   localparam int unsigned DEST_W = 2;
   localparam int unsigned ID_W   = 2;
   localparam int unsigned CW     = 32;
   localparam int unsigned NR     = 4;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned TS_W   = DW / 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [15:0]       load;
   logic [CW-1:0]     num_packets;
   logic              start;
   logic [TS_W-1:0]   ticks;
   logic              done;
   logic [CW-1:0]     sent_packets [NR];
   logic [CW-1:0]     total_sent_packets;
   logic              axis_out_tvalid;
   logic              axis_out_tready;
   logic [DW-1:0]     axis_out_tdata;
   logic              axis_out_tlast;
   logic [ID_W-1:0]   axis_out_tid;
   logic [DEST_W-1:0] axis_out_tdest;

   always #5 clk = ~clk;

   axis_traffic_gen #(
      .TDATA_WIDTH(DW), .TDEST_WIDTH(DEST_W), .TID_WIDTH(ID_W), .COUNT_WIDTH(CW),
      .NUM_ROUTERS(NR), .TID(0), .SEED(2), .PENDING_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .num_packets(num_packets), .start(start),
      .ticks(ticks), .done(done), .sent_packets(sent_packets),
      .total_sent_packets(total_sent_packets), .axis_out_tvalid(axis_out_tvalid),
      .axis_out_tready(axis_out_tready), .axis_out_tdata(axis_out_tdata),
      .axis_out_tlast(axis_out_tlast), .axis_out_tid(axis_out_tid),
      .axis_out_tdest(axis_out_tdest)
   );

   int n_cmp;
   int n_bad;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: packets waiting to leave, in generation order.
   typedef struct { logic [TS_W-1:0] ts; logic [DEST_W-1:0] dest; } flit_t;
   typedef enum int {PH_IDLE, PH_ARMED, PH_RUN, PH_DRAIN, PH_DONE} phase_t;

   flit_t         mq[$];
   phase_t        m_phase;
   logic [15:0]   m_rate, m_dlfsr;
   logic [CW-1:0] m_gen, m_total;
   logic [CW-1:0] m_sent [NR];

   // Handshakes observed on the DUT port.
   typedef struct { longint cyc; logic [DEST_W-1:0] dest; logic [TS_W-1:0] ts; } hs_t;
   hs_t           hs_log[$];
   longint        cyc_cnt;
   longint        run_base;
   logic [TS_W-1:0] run_ticks;
   int unsigned   ready_pct;
   bit            ready_alt;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return (v >> 1) ^ (((v & 16'd1) != 16'd0) ? 16'hB400 : 16'h0000);
   endfunction

   task automatic m_reset();
      m_phase = PH_IDLE;
      mq.delete();
      m_rate  = 16'd2;
      m_dlfsr = 16'd2 ^ 16'hACE1;
      if (m_dlfsr == 16'd0) m_dlfsr = 16'd1;
      m_gen   = '0;
      m_total = '0;
      for (int i = 0; i < NR; i++) m_sent[i] = '0;
   endtask

   // Apply the effect of the coming clock edge with the inputs now driven.
   task automatic model_edge();
      int unsigned pre;
      logic pop, gen;
      flit_t f, h;
      if (!rst_n) begin
         m_reset();
         return;
      end
      pre    = mq.size();
      pop    = (pre != 0) && axis_out_tready;
      gen    = 1'b0;
      f.ts   = ticks;
      f.dest = m_dlfsr[DEST_W-1:0];
      case (m_phase)
         PH_IDLE:  if (start) m_phase = PH_ARMED;
         PH_ARMED: m_phase = PH_RUN;
         PH_RUN: begin
            if (m_gen >= num_packets) m_phase = PH_DRAIN;
            else gen = (m_rate <= load) && (pre < DEPTH || pop);
            m_rate  = lfsr_step(m_rate);
            m_dlfsr = lfsr_step(m_dlfsr);
         end
         PH_DRAIN: if (pre == 0) m_phase = PH_DONE;
         default: ;
      endcase
      if (pop) begin
         h = mq.pop_front();
         m_sent[h.dest] = m_sent[h.dest] + 1;
         m_total = m_total + 1;
      end
      if (gen) begin
         mq.push_back(f);
         m_gen = m_gen + 1;
      end
   endtask

   task automatic compare_outputs();
      check("tvalid", 64'(axis_out_tvalid), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
         check("tdest", 64'(axis_out_tdest), 64'(mq[0].dest));
         check("tdata", axis_out_tdata, {mq[0].ts, m_sent[mq[0].dest]});
         check("tlast", 64'(axis_out_tlast), 64'(1));
         check("tid", 64'(axis_out_tid), 64'(0));
      end
      check("done", 64'(done), 64'(m_phase == PH_DONE));
      check("total", 64'(total_sent_packets), 64'(m_total));
   endtask

   task automatic cycle();
      logic hs;
      hs_t  e;
      if (ready_alt) axis_out_tready = (((cyc_cnt - run_base) % 2) == 0);
      else           axis_out_tready = ($urandom_range(99, 0) < ready_pct);
      ticks  = ticks + 1'b1;
      hs     = axis_out_tvalid && axis_out_tready && rst_n;
      e.cyc  = cyc_cnt;
      e.dest = axis_out_tdest;
      e.ts   = axis_out_tdata[DW-1:TS_W];
      model_edge();
      @(posedge clk);
      cyc_cnt++;
      if (hs) hs_log.push_back(e);
      @(negedge clk);
      compare_outputs();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
      hs_log.delete();
   endtask

   task automatic start_run(input logic [15:0] ld, input logic [CW-1:0] np);
      do_reset();
      load        = ld;
      num_packets = np;
      run_base    = cyc_cnt;
      run_ticks   = ticks;
      start       = 1'b1;
      cycle();
      start       = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      logic [CW-1:0] sum;
      for (int c = 0; c < budget && m_phase != PH_DONE; c++) cycle();
      check({tag, "_done"}, 64'(done), 64'(1));
      sum = '0;
      for (int i = 0; i < NR; i++) begin
         check({tag, "_sent"}, 64'(sent_packets[i]), 64'(m_sent[i]));
         sum = sum + sent_packets[i];
      end
      check({tag, "_sum"}, 64'(sum), 64'(num_packets));
   endtask

   logic [DEST_W-1:0] sv_dest [5];
   logic [TS_W-1:0]   sv_ts   [5];
   longint            gap_x1000;

   initial begin
      n_cmp = 0; n_bad = 0;
      rst_n = 1'b0; start = 1'b0; load = '0; num_packets = '0; ticks = '0;
      axis_out_tready = 1'b0; ready_pct = 100; ready_alt = 1'b0;
      cyc_cnt = 0; run_base = 0; run_ticks = '0;
      m_reset();

      // Reset state
      do_reset();
      check("rst_tvalid", 64'(axis_out_tvalid), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_total", 64'(total_sent_packets), 64'(0));
      for (int i = 0; i < NR; i++) check("rst_sent", 64'(sent_packets[i]), 64'(0));

      // Full load, back-to-back flits
      ready_pct = 100;
      start_run(16'hFFFF, 8);
      wait_done(100, "full");
      check("full_total", 64'(total_sent_packets), 64'(8));
      check("full_count", 64'(hs_log.size()), 64'(8));
      if (hs_log.size() == 8) begin
         check("full_first_hs", 64'(hs_log[0].cyc - run_base), 64'(3));
         check("full_last_hs", 64'(hs_log[7].cyc - run_base), 64'(10));
      end

      // Backpressure: FIFO fills and holds
      ready_pct = 0;
      start_run(16'hFFFF, 20);
      repeat (30) cycle();
      check("bp_hold_valid", 64'(axis_out_tvalid), 64'(1));
      check("bp_hold_total", 64'(total_sent_packets), 64'(0));
      ready_pct = 100;
      wait_done(200, "bp");
      check("bp_count", 64'(hs_log.size()), 64'(20));
      for (int i = 1; i < hs_log.size(); i++)
         check("bp_ts_order", 64'(hs_log[i].ts >= hs_log[i-1].ts), 64'(1));

      // Zero load never injects
      start_run(16'h0000, 10);
      repeat (1000) cycle();
      check("ld0_done", 64'(done), 64'(0));
      check("ld0_total", 64'(total_sent_packets), 64'(0));
      check("ld0_count", 64'(hs_log.size()), 64'(0));

      // Empty run completes quickly
      start_run(16'hFFFF, 0);
      wait_done(3, "np0");
      check("np0_count", 64'(hs_log.size()), 64'(0));

      // Reset mid-run, then rerun must repeat the same traffic
      ready_alt = 1'b1;
      start_run(16'hFFFF, 20);
      for (int c = 0; c < 200 && hs_log.size() < 5; c++) cycle();
      check("mid_sends", 64'(hs_log.size() >= 5), 64'(1));
      for (int i = 0; i < 5; i++) begin
         sv_dest[i] = hs_log[i].dest;
         sv_ts[i]   = hs_log[i].ts - run_ticks;
      end
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      check("mid_rst_tvalid", 64'(axis_out_tvalid), 64'(0));
      check("mid_rst_done", 64'(done), 64'(0));
      check("mid_rst_total", 64'(total_sent_packets), 64'(0));
      for (int i = 0; i < NR; i++) check("mid_rst_sent", 64'(sent_packets[i]), 64'(0));
      start_run(16'hFFFF, 20);
      wait_done(300, "rerun");
      check("rerun_count", 64'(hs_log.size()), 64'(20));
      if (hs_log.size() >= 5) begin
         for (int i = 0; i < 5; i++) begin
            check("rerun_dest", 64'(hs_log[i].dest), 64'(sv_dest[i]));
            check("rerun_ts", 64'(hs_log[i].ts - run_ticks), 64'(sv_ts[i]));
         end
      end
      ready_alt = 1'b0;

      // Half load: mean gap of two cycles
      ready_pct = 100;
      start_run(16'h8000, 4096);
      wait_done(12000, "gap");
      check("gap_total", 64'(total_sent_packets), 64'(4096));
      check("gap_count", 64'(hs_log.size()), 64'(4096));
      if (hs_log.size() == 4096) begin
         gap_x1000 = ((hs_log[4095].cyc - hs_log[0].cyc) * 1000) / 4095;
         check("gap_avg_range", 64'(gap_x1000 >= 1900 && gap_x1000 <= 2100), 64'(1));
      end

      // Random loads, sizes and ready rates
      for (int r = 0; r < 8; r++) begin
         ready_pct = $urandom_range(100, 10);
         start_run(16'($urandom_range(16'hFFFF, 16'h2000)), CW'($urandom_range(40, 0)));
         wait_done(4000, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
